// File: rtl/icache_sa.sv
// icache_sa: WAYS-way set-associative instruction cache with an internal line-refill FSM.
// Virtually indexed from fetch0 (addr[11:2]), physically tagged from fetch1, refills over a
// simple req/ack + rvalid beat memory port.
module icache_sa #(
    parameter int WAYS       = 2,
    parameter int LINE_WORDS = 4,
    parameter int PA_MSB     = 28,
    localparam int OFF       = $clog2(LINE_WORDS)
) (
    input  logic                  clk_core,
    input  logic                  reset,
    input  logic                  fe0_read_req,
    input  logic [11:2]           fe0_read_addr,
    input  logic [PA_MSB:12]      fe1_read_tag,
    input  logic                  fe1_flush,
    output logic                  ic_read_hit,
    output logic                  ic_read_miss,
    output logic [31:0]           ic_read_data,
    output logic                  ic_busy,
    output logic                  ic_mem_req,
    output logic [PA_MSB:2+OFF]   ic_mem_addr,
    input  logic                  mem_ack,
    input  logic                  mem_rvalid,
    input  logic [31:0]           mem_rdata
);

    localparam int OFFW = (OFF > 0) ? OFF : 1;
    localparam int SETS = 1024 / LINE_WORDS;
    localparam int IDXW = 10 - OFF;
    localparam int TAGW = PA_MSB - 11;
    localparam int WAYW = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_FILL
    } state_t;

    state_t r_state;
    state_t w_next;

    // Tag / data arrays (synchronous read) and their read registers
    logic [TAGW-1:0]  r_tag_ram  [WAYS][SETS];
    logic [31:0]      r_data_ram [WAYS][1024];
    logic [TAGW-1:0]  r_tag_q    [WAYS];
    logic [31:0]      r_data_q   [WAYS];

    // Valid bits and round-robin victim pointers in flops
    logic [WAYS-1:0]  r_valid [SETS];
    logic [WAYW-1:0]  r_rr    [SETS];

    // Lookup pipeline
    logic             r_lookup;
    logic [IDXW-1:0]  r_idx;

    // Refill context
    logic [TAGW-1:0]  r_ftag;
    logic [IDXW-1:0]  r_fidx;
    logic [WAYW-1:0]  r_vict;
    logic [OFFW-1:0]  r_beat;
    logic             r_poison;

    logic             w_accept;
    logic [IDXW-1:0]  w_idx;
    logic [WAYS-1:0]  w_hit_way;
    logic             w_has_inv;
    logic [WAYW-1:0]  w_inv_way;
    logic [WAYW-1:0]  w_victim;
    logic             w_last_beat;
    logic             w_beat_we;
    logic [9:0]       w_fill_addr;

    assign w_idx        = fe0_read_addr[11:2+OFF];
    assign ic_read_hit  = |w_hit_way;
    assign ic_read_miss = r_lookup && !ic_read_hit;
    assign ic_busy      = (r_state != S_IDLE) || ic_read_miss;
    assign w_accept     = fe0_read_req && !ic_busy;
    assign w_last_beat  = (r_beat == OFFW'(LINE_WORDS - 1));
    assign w_beat_we    = (r_state == S_FILL) && mem_rvalid;
    assign w_fill_addr  = (10'(r_fidx) << OFF) | 10'(r_beat);

    // Per-way tag compare and hit-word select
    always_comb begin
        w_hit_way    = '0;
        ic_read_data = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (r_lookup && r_valid[r_idx][w] && (r_tag_q[w] == fe1_read_tag)) begin
                w_hit_way[w] = 1'b1;
            end
        end
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (w_hit_way[w]) begin
                ic_read_data = ic_read_data | r_data_q[w];
            end
        end
    end

    // Victim choice: lowest invalid way, otherwise the set's round-robin pointer
    always_comb begin
        w_has_inv = 1'b0;
        w_inv_way = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (!w_has_inv && !r_valid[r_idx][w]) begin
                w_has_inv = 1'b1;
                w_inv_way = WAYW'(w);
            end
        end
        w_victim = w_has_inv ? w_inv_way : r_rr[r_idx];
    end

    // FSM state register
    always_ff @(posedge clk_core) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // FSM next state and memory-port outputs
    always_comb begin
        w_next      = r_state;
        ic_mem_req  = 1'b0;
        ic_mem_addr = '0;
        case (r_state)
            S_IDLE: begin
                if (ic_read_miss) begin
                    w_next = S_REQ;
                end
            end
            S_REQ: begin
                ic_mem_req  = 1'b1;
                ic_mem_addr = {r_ftag, r_fidx};
                if (mem_ack) begin
                    w_next = S_FILL;
                end
            end
            S_FILL: begin
                if (mem_rvalid && w_last_beat) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Lookup pipeline and refill context (tag/index/victim latched in the miss cycle)
    always_ff @(posedge clk_core) begin
        if (reset) begin
            r_lookup <= 1'b0;
            r_idx    <= '0;
            r_ftag   <= '0;
            r_fidx   <= '0;
            r_vict   <= '0;
            r_beat   <= '0;
            r_poison <= 1'b0;
        end else begin
            r_lookup <= w_accept;
            if (w_accept) begin
                r_idx <= w_idx;
            end
            if (ic_read_miss) begin
                r_ftag   <= fe1_read_tag;
                r_fidx   <= r_idx;
                r_vict   <= w_victim;
                r_beat   <= '0;
                r_poison <= fe1_flush;
            end else if ((r_state != S_IDLE) && fe1_flush) begin
                r_poison <= 1'b1;
            end
            if (w_beat_we) begin
                r_beat <= w_last_beat ? '0 : OFFW'(r_beat + 1'b1);
            end
        end
    end

    // Valid bits and RR pointers; flush shares the reset path so it overrides a same-cycle fill
    always_ff @(posedge clk_core) begin
        if (reset || fe1_flush) begin
            for (int unsigned s = 0; s < SETS; s++) begin
                r_valid[s] <= '0;
                r_rr[s]    <= '0;
            end
        end else begin
            if (ic_read_miss) begin
                r_valid[r_idx][w_victim] <= 1'b0;
                if (!w_has_inv) begin
                    r_rr[r_idx] <= (WAYS > 1) ? WAYW'(r_rr[r_idx] + 1'b1) : '0;
                end
            end
            if (w_beat_we && w_last_beat && !r_poison) begin
                r_valid[r_fidx][r_vict] <= 1'b1;
            end
        end
    end

    // Array read on accepted lookup; refill writes beats and, on the last beat, the tag
    always_ff @(posedge clk_core) begin
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (w_accept) begin
                r_tag_q[w]  <= r_tag_ram[w][w_idx];
                r_data_q[w] <= r_data_ram[w][fe0_read_addr];
            end
            if (w_beat_we && (WAYW'(w) == r_vict)) begin
                r_data_ram[w][w_fill_addr] <= mem_rdata;
                if (w_last_beat) begin
                    r_tag_ram[w][r_fidx] <= r_ftag;
                end
            end
        end
    end

endmodule
